alu_issue_stage: RTL and testbench

- ID/EX pipeline stage sitting directly upstream of the 32-bit ALU; registers decoded operands and presents them on the ALU's A/B/ALUCntl/CarryIn inputs.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages, sign-extends immediates and derives the 4-bit ALU control code from ALUOp/funct.
- Single output register with valid/ready handshake, stall back-pressure and flush for branch squash.

---
 rtl/mips_pkg.sv | 63 ++++++
 rtl/fwd_mux.sv | 34 +++
 rtl/alu_issue_stage.sv | 120 ++++++++++++
 tb/tb_alu_issue_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: ALUOp encodings, ALU control codes,
// R-type funct values and the ALU-control decode function.
package mips_pkg;

  localparam int unsigned ALU_OP_W   = 2;
  localparam int unsigned ALU_CTL_W  = 4;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned IMM_W      = 16;

  // Main-decoder ALUOp encodings
  typedef enum logic [ALU_OP_W-1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  // ALU function codes
  typedef enum logic [ALU_CTL_W-1:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SUB  = 4'b0110,
    ALU_NOR  = 4'b1100,
    ALU_PASS = 4'b1111
  } alu_cntl_e;

  // R-type funct field values
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR = 6'b100110;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'b100111;

  // ALUOp/funct -> ALU control; unknown R-type funct makes the ALU pass A
  function automatic logic [ALU_CTL_W-1:0] alu_decode(
    input logic [ALU_OP_W-1:0] op,
    input logic [FUNCT_W-1:0]  fn
  );
    logic [ALU_CTL_W-1:0] code;
    code = ALU_PASS;
    case (op)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_OR:  code = ALU_OR;
      default: begin
        case (fn)
          FUNCT_ADD: code = ALU_ADD;
          FUNCT_SUB: code = ALU_SUB;
          FUNCT_AND: code = ALU_AND;
          FUNCT_OR:  code = ALU_OR;
          FUNCT_XOR: code = ALU_XOR;
          FUNCT_NOR: code = ALU_NOR;
          default:   code = ALU_PASS;
        endcase
      end
    endcase
    return code;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding selector for one source register.
// EX/MEM result beats MEM/WB result, which beats register-file data.
// Register 0 is hard-wired and never forwarded.
// Ports: src_num/rf_data (source), exmem_*/memwb_* (later-stage writes),
//        fwd_data_c (combinational selected operand).
module fwd_mux #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic [RW-1:0] src_num,
  input  logic [DW-1:0] rf_data,
  input  logic          exmem_wr,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_data,
  input  logic          memwb_wr,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic [DW-1:0] fwd_data_c
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_wr && (exmem_rd != RW'(0)) && (exmem_rd == src_num);
  assign memwb_hit = memwb_wr && (memwb_rd != RW'(0)) && (memwb_rd == src_num);

  // Priority select: newest producer first
  always_comb begin
    fwd_data_c = rf_data;
    if (exmem_hit)      fwd_data_c = exmem_data;
    else if (memwb_hit) fwd_data_c = memwb_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding the 32-bit ALU: resolves forwarding, sign-extends
// the immediate, decodes ALU control and registers A/B/ALUCntl/CarryIn/dest_num
// behind a valid/ready handshake with flush.
// Inputs : clk, rst_n, in_valid, rs/rt_data, imm16, rs/rt/rd_num, alu_op, funct,
//          alu_src, exmem_*/memwb_* forwarding sources, flush, out_ready.
// Outputs: in_ready (combinational), out_valid, A, B, ALUCntl, CarryIn, dest_num.
// Option : ALU_ISSUE_STALL_CNT_EN adds a saturating stall_cnt[15:0] output.
module alu_issue_stage
  import mips_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        rs_data,
  input  logic [DW-1:0]        rt_data,
  input  logic [IMM_W-1:0]     imm16,
  input  logic [RW-1:0]        rs_num,
  input  logic [RW-1:0]        rt_num,
  input  logic [RW-1:0]        rd_num,
  input  logic [ALU_OP_W-1:0]  alu_op,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 alu_src,
  input  logic                 exmem_wr,
  input  logic                 memwb_wr,
  input  logic [RW-1:0]        exmem_rd,
  input  logic [RW-1:0]        memwb_rd,
  input  logic [DW-1:0]        exmem_data,
  input  logic [DW-1:0]        memwb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        A,
  output logic [DW-1:0]        B,
  output logic [ALU_CTL_W-1:0] ALUCntl,
  output logic                 CarryIn,
`ifdef ALU_ISSUE_STALL_CNT_EN
  output logic [15:0]          stall_cnt,
`endif
  output logic [RW-1:0]        dest_num
);

  logic [DW-1:0]        rs_fwd_c;
  logic [DW-1:0]        rt_fwd_c;
  logic [DW-1:0]        imm_ext_c;
  logic [DW-1:0]        b_next_c;
  logic [ALU_CTL_W-1:0] cntl_next_c;
  logic                 load_c;

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src_num    (rs_num),
    .rf_data    (rs_data),
    .exmem_wr   (exmem_wr),
    .exmem_rd   (exmem_rd),
    .exmem_data (exmem_data),
    .memwb_wr   (memwb_wr),
    .memwb_rd   (memwb_rd),
    .memwb_data (memwb_data),
    .fwd_data_c (rs_fwd_c)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src_num    (rt_num),
    .rf_data    (rt_data),
    .exmem_wr   (exmem_wr),
    .exmem_rd   (exmem_rd),
    .exmem_data (exmem_data),
    .memwb_wr   (memwb_wr),
    .memwb_rd   (memwb_rd),
    .memwb_data (memwb_data),
    .fwd_data_c (rt_fwd_c)
  );

  // Handshake: accept when the output slot is empty or being consumed
  assign in_ready = !out_valid || out_ready;
  assign load_c   = in_valid && in_ready && !flush;

  // Operand B select and control decode
  assign imm_ext_c   = {{(DW-IMM_W){imm16[IMM_W-1]}}, imm16};
  assign b_next_c    = alu_src ? imm_ext_c : rt_fwd_c;
  assign cntl_next_c = alu_decode(alu_op, funct);

  // Valid flag: flush wins, otherwise refill/drain whenever the slot frees
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        out_valid <= 1'b0;
    else if (flush)    out_valid <= 1'b0;
    else if (in_ready) out_valid <= in_valid;
  end

  // Payload register: only written on an accepted, unflushed load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A        <= '0;
      B        <= '0;
      ALUCntl  <= ALU_CTL_W'(0);
      CarryIn  <= 1'b0;
      dest_num <= '0;
    end else if (load_c) begin
      A        <= rs_fwd_c;
      B        <= b_next_c;
      ALUCntl  <= cntl_next_c;
      CarryIn  <= 1'b0;
      dest_num <= rd_num;
    end
  end

`ifdef ALU_ISSUE_STALL_CNT_EN
  // Saturating count of cycles the ALU back-pressures a valid operand set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= 16'd0;
    else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] rs_data, rt_data;
  logic [15:0]   imm16;
  logic [RW-1:0] rs_num, rt_num, rd_num;
  logic [1:0]    alu_op;
  logic [5:0]    funct;
  logic          alu_src;
  logic          exmem_wr, memwb_wr;
  logic [RW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_data, memwb_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] A, B;
  logic [3:0]    ALUCntl;
  logic          CarryIn;
  logic [RW-1:0] dest_num;
`ifdef ALU_ISSUE_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  alu_issue_stage #(.DW(DW), .RW(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .imm16      (imm16),
    .rs_num     (rs_num),
    .rt_num     (rt_num),
    .rd_num     (rd_num),
    .alu_op     (alu_op),
    .funct      (funct),
    .alu_src    (alu_src),
    .exmem_wr   (exmem_wr),
    .memwb_wr   (memwb_wr),
    .exmem_rd   (exmem_rd),
    .memwb_rd   (memwb_rd),
    .exmem_data (exmem_data),
    .memwb_data (memwb_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .A          (A),
    .B          (B),
    .ALUCntl    (ALUCntl),
    .CarryIn    (CarryIn),
`ifdef ALU_ISSUE_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .dest_num   (dest_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; rs_data = '0; rt_data = '0; imm16 = '0;
    rs_num = '0; rt_num = '0; rd_num = '0; alu_op = 2'b00; funct = '0;
    alu_src = 0; exmem_wr = 0; memwb_wr = 0; exmem_rd = '0; memwb_rd = '0;
    exmem_data = '0; memwb_data = '0; flush = 0; out_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if ({A, B} !== 64'd0) begin n_bad++; $display("FAIL reset_ab got=%h/%h exp=0/0", A, B); end
    n_cmp++; if ({ALUCntl, CarryIn, dest_num} !== 10'd0) begin n_bad++; $display("FAIL reset_ctl got=%b/%b/%0d exp=0", ALUCntl, CarryIn, dest_num); end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_add();
    // add $3,$1,$2
    in_valid = 1; rs_num = 1; rt_num = 2; rd_num = 3; rs_data = 5; rt_data = 7;
    alu_op = 2'b10; funct = 6'b100000;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    n_cmp++; if (A !== 32'd5 || B !== 32'd7) begin n_bad++; $display("FAIL add_ab got=%0d/%0d exp=5/7", A, B); end
    n_cmp++; if (ALUCntl !== 4'b0010 || dest_num !== 5'd3 || CarryIn !== 1'b0) begin n_bad++; $display("FAIL add_ctl got=%b/%0d/%b exp=0010/3/0", ALUCntl, dest_num, CarryIn); end
    // drain: no new instruction, data retained
    in_valid = 0; rs_data = 99;
    step();
    n_cmp++; if (out_valid !== 1'b0 || A !== 32'd5) begin n_bad++; $display("FAIL drain got v=%b A=%0d exp v=0 A=5", out_valid, A); end
  endtask

  task automatic test_forward();
    in_valid = 1; rs_num = 4; rs_data = 32'h11; rt_num = 6; rt_data = 32'h22;
    alu_op = 2'b00; rd_num = 7;
    exmem_wr = 1; exmem_rd = 4; exmem_data = 32'hAA;
    memwb_wr = 1; memwb_rd = 4; memwb_data = 32'hBB;
    step();
    n_cmp++; if (A !== 32'hAA) begin n_bad++; $display("FAIL fwd_exmem got=%h exp=aa", A); end
    n_cmp++; if (B !== 32'h22) begin n_bad++; $display("FAIL fwd_rt_nomatch got=%h exp=22", B); end
    exmem_wr = 0;
    step();
    n_cmp++; if (A !== 32'hBB) begin n_bad++; $display("FAIL fwd_memwb got=%h exp=bb", A); end
    // register 0 never forwarded
    rs_num = 0; exmem_wr = 1; exmem_rd = 0; memwb_rd = 0;
    step();
    n_cmp++; if (A !== 32'h11) begin n_bad++; $display("FAIL fwd_r0 got=%h exp=11", A); end
    // rt path forwarding from MEM/WB
    rt_num = 9; exmem_rd = 8; memwb_rd = 9; memwb_data = 32'hCAFE_0001;
    step();
    n_cmp++; if (B !== 32'hCAFE_0001) begin n_bad++; $display("FAIL fwd_rt got=%h exp=cafe0001", B); end
    idle_inputs();
    step();
  endtask

  task automatic test_addi();
    in_valid = 1; rs_num = 1; rs_data = 32'd100; rt_data = 32'h1234;
    alu_src = 1; imm16 = 16'hFFFE; alu_op = 2'b00; rd_num = 2;
    step();
    n_cmp++; if (B !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL addi_b got=%h exp=fffffffe", B); end
    n_cmp++; if (ALUCntl !== 4'b0010) begin n_bad++; $display("FAIL addi_ctl got=%b exp=0010", ALUCntl); end
    imm16 = 16'h7FFF;
    step();
    n_cmp++; if (B !== 32'h0000_7FFF) begin n_bad++; $display("FAIL addi_pos got=%h exp=00007fff", B); end
    idle_inputs();
    step();
  endtask

  task automatic test_decode();
    logic [1:0] ops [11];
    logic [5:0] fns [11];
    logic [3:0] exp [11];
    ops = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    fns = '{6'h2A, 6'h2A, 6'h2A, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00};
    exp = '{4'b0010, 4'b0110, 4'b0001, 4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b1100, 4'b1111, 4'b1111};
    in_valid = 1;
    for (int i = 0; i < 11; i++) begin
      alu_op = ops[i]; funct = fns[i];
      step();
      n_cmp++; if (ALUCntl !== exp[i]) begin n_bad++; $display("FAIL decode_%0d op=%b fn=%b got=%b exp=%b", i, ops[i], fns[i], ALUCntl, exp[i]); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_hold();
    in_valid = 1; rs_num = 1; rs_data = 32'h100; rd_num = 10; alu_op = 2'b00;
    step();
    // back-pressure with a new instruction waiting
    out_ready = 0; rs_data = 32'h200; rd_num = 11;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1 || A !== 32'h100 || dest_num !== 5'd10) begin n_bad++; $display("FAIL hold_%0d got v=%b A=%h d=%0d exp v=1 A=100 d=10", i, out_valid, A, dest_num); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready_%0d got=%b exp=0", i, in_ready); end
    end
`ifdef ALU_ISSUE_STALL_CNT_EN
    n_cmp++; if (stall_cnt !== 16'd3) begin n_bad++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
`endif
    out_ready = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready got=%b exp=1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || A !== 32'h200 || dest_num !== 5'd11) begin n_bad++; $display("FAIL release_load got v=%b A=%h d=%0d exp v=1 A=200 d=11", out_valid, A, dest_num); end
`ifdef ALU_ISSUE_STALL_CNT_EN
    n_cmp++; if (stall_cnt !== 16'd3) begin n_bad++; $display("FAIL stall_cnt_after got=%0d exp=3", stall_cnt); end
`endif
    idle_inputs();
    step();
  endtask

  task automatic test_flush();
    in_valid = 1; rs_num = 1; rs_data = 32'h300; rd_num = 12;
    step();
    n_cmp++; if (out_valid !== 1'b1 || A !== 32'h300) begin n_bad++; $display("FAIL flush_pre got v=%b A=%h exp v=1 A=300", out_valid, A); end
    flush = 1; rs_data = 32'h400; rd_num = 13;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    n_cmp++; if (A !== 32'h300 || dest_num !== 5'd12) begin n_bad++; $display("FAIL flush_noload got A=%h d=%0d exp A=300 d=12", A, dest_num); end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_midstream();
    in_valid = 1; rs_num = 1; rs_data = 32'h55; rt_data = 32'h66; rd_num = 14;
    alu_op = 2'b10; funct = 6'b100010;
    step();
    n_cmp++; if (out_valid !== 1'b1 || A !== 32'h55) begin n_bad++; $display("FAIL mid_pre got v=%b A=%h exp v=1 A=55", out_valid, A); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || A !== 32'd0 || B !== 32'd0) begin n_bad++; $display("FAIL mid_reset got v=%b A=%h B=%h exp 0/0/0", out_valid, A, B); end
    n_cmp++; if (ALUCntl !== 4'b0000 || dest_num !== 5'd0) begin n_bad++; $display("FAIL mid_reset_ctl got=%b/%0d exp=0000/0", ALUCntl, dest_num); end
`ifdef ALU_ISSUE_STALL_CNT_EN
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_reset_cnt got=%0d exp=0", stall_cnt); end
`endif
    idle_inputs();
    step();
    rst_n = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_addi();
    test_decode();
    test_hold();
    test_flush();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
